round_pipe: RTL and testbench
=============================

Name: round_pipe

Overview:
- Parametrised, pipelined rounding stage for the FP datapath.
- Takes sign, extended biased exponent, truncated mantissa and guard/sticky bits, and applies the `rounding_pkg` rounding mode.
- Handles mantissa carry, exponent overflow to inf/max-finite and flush-to-zero underflow.
- Packs the IEEE-style result and raises exception flags; sits between the normaliser and the result register, with a valid/ready handshake on both sides.

Parameters:
- EXP_W, 8, stored exponent width.
- MAN_W, 23, stored mantissa (fraction) width.
- XEXP_W, EXP_W+2, width of the signed two's-complement pre-round exponent.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_sign  in  1  result sign.
- in_exponent  in  XEXP_W  signed biased exponent before rounding.
- in_mantissa  in  MAN_W  fraction bits, hidden bit excluded.
- in_guard  in  1  first discarded bit.
- in_sticky  in  1  OR of remaining discarded bits.
- round_mode  in  3  `rounding_pkg` encoding, sampled with the beat.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- z  out  1+EXP_W+MAN_W  packed result {sign, exponent, fraction}.
- inexact  out  1  result differs from the exact value.
- overflow  out  1  rounded exponent out of range.
- underflow  out  1  flushed to zero.
- flags_clr  in  1  clears accumulated flags (used only with the optional feature).
- flags_acc  out  3  accumulated {overflow, underflow, inexact} (used only with the optional feature).

Behaviour:
- Pipeline: 2 stages, latency 2 cycles from the accepted beat to out_valid.
- Advance rule: adv = !out_valid || out_ready; in_ready = adv.
  - On adv, both stages shift and the s1 valid bit loads in_valid.
  - When !adv, all stage registers hold; out_valid and z stay stable while stalled.
- Reset:
  - out_valid=0, the internal s1 valid=0, z=0, and all flags=0.
  - flags_acc=0 when the feature is compiled in.
  - Reset mid-stream drops in-flight beats.
- Stage 1, increment decision (inexact = guard|sticky):
  - IEEE_near: guard & (sticky | lsb).
  - IEEE_zero: never.
  - IEEE_pinf: !sign & inexact.
  - IEEE_ninf: sign & inexact.
  - near_up: guard.
  - away_zero: inexact, either sign.
  - Any other code behaves as IEEE_near.
  - The mantissa increment is computed MAN_W+1 wide and registered together with the carry out.
- Stage 2, carry: on carry out, the fraction becomes all zeros and the exponent is incremented. The hidden bit rolls into 10.0… and is renormalised; no bit is lost.
- Stage 2, overflow: triggered when the post-round exponent ≥ 2^EXP_W−1 (signed compare). Raises overflow=1 and inexact=1.
  - Result is inf for IEEE_near, near_up and away_zero.
  - Result is max-finite (exponent 2^EXP_W−2, fraction all ones) for IEEE_zero, for IEEE_pinf with sign=1, and for IEEE_ninf with sign=0.
  - The other directed cases (IEEE_pinf with sign=0, IEEE_ninf with sign=1) give inf.
- Stage 2, underflow: triggered when the pre-round exponent ≤ 0. Result is signed zero {sign, 0, 0}, with underflow=1 and inexact=1.
- Precedence: underflow is checked first, then overflow.
- The sign always passes through unchanged.
- Flags are per-beat and qualified by out_valid.

Optional Feature:
- Macro: ROUND_FLAGS_STICKY_EN.
- When defined:
  - flags_acc ORs in {overflow, underflow, inexact} on every handshake (out_valid & out_ready).
  - flags_clr=1 zeroes flags_acc on the next edge; a same-cycle handshake is still ORed in after the clear.
  - flags_acc is reset to 0.
- When undefined: flags_acc is tied to 0 and flags_clr is ignored.

Test Plan:
- Nearest, tie: exp=127, mant=0x000001, guard=1, sticky=0, IEEE_near → z=0x3F800002, inexact=1.
- Carry: exp=127, mant=0x7FFFFF, guard=1, IEEE_near → z=0x40000000, overflow=0.
- Overflow by mode: exp=254, mant=0x7FFFFF, guard=1, sign=0.
  - IEEE_near → z=0x7F800000, overflow=1.
  - IEEE_zero → z=0x7F7FFFFF.
- Directed modes: sign=1, exp=127, mant=0, sticky=1.
  - IEEE_ninf → z=0xBF800001.
  - IEEE_pinf → z=0xBF800000.
  - away_zero → z=0xBF800001.
- Backpressure: stream 4 beats with out_ready low for 3 cycles mid-stream → in_ready drops, no beat is lost or duplicated, order is preserved, and z is stable during the stall.
- Reset and flags: assert rst with 2 beats in flight → out_valid=0 next cycle. With ROUND_FLAGS_STICKY_EN, an underflow beat followed by clean beats keeps flags_acc=3'b011 until flags_clr.

Source files
------------

// File: rtl/round_pipe.sv
// round_pipe: two-stage rounding stage (increment decision, carry, overflow/underflow, packing).
// Build option ROUND_FLAGS_STICKY_EN adds the accumulated exception flags on flags_acc.
module round_pipe #(
    parameter int EXP_W  = 8,
    parameter int MAN_W  = 23,
    parameter int XEXP_W = EXP_W + 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_sign,
    input  logic [XEXP_W-1:0]      in_exponent,
    input  logic [MAN_W-1:0]       in_mantissa,
    input  logic                   in_guard,
    input  logic                   in_sticky,
    input  logic [2:0]             round_mode,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   z,
    output logic                   inexact,
    output logic                   overflow,
    output logic                   underflow,
    input  logic                   flags_clr,
    output logic [2:0]             flags_acc
);

    localparam logic [2:0] RND_IEEE_NEAR = 3'd0;
    localparam logic [2:0] RND_IEEE_ZERO = 3'd1;
    localparam logic [2:0] RND_IEEE_PINF = 3'd2;
    localparam logic [2:0] RND_IEEE_NINF = 3'd3;
    localparam logic [2:0] RND_NEAR_UP   = 3'd4;
    localparam logic [2:0] RND_AWAY_ZERO = 3'd5;

    // One bit wider than the pre-round exponent so a carry into the top code never wraps.
    localparam logic signed [XEXP_W:0] EXP_LIMIT = (XEXP_W+1)'((1 << EXP_W) - 1);

    localparam logic [EXP_W+MAN_W:0] MAG_ZERO = '0;
    localparam logic [EXP_W-1:0]     EXP_INF  = '1;
    localparam logic [EXP_W-1:0]     EXP_MAXF = {{(EXP_W-1){1'b1}}, 1'b0};
    localparam logic [MAN_W-1:0]     MAN_ONES = '1;
    localparam logic [MAN_W-1:0]     MAN_ZERO = '0;

    // Handshake: a beat moves on a clock edge where valid and ready are both high; once
    // out_valid is raised the result and flags hold until out_ready takes them.
    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // ------------------------------------------------------------------
    // Stage 1: increment decision and widened mantissa increment
    // ------------------------------------------------------------------
    logic             in_inexact;
    logic             inc;
    logic             maxfin;
    logic             pre_uf;
    logic [MAN_W:0]   man_rnd;

    assign in_inexact = in_guard | in_sticky;
    assign pre_uf     = in_exponent[XEXP_W-1] || (in_exponent == '0);
    assign man_rnd    = {1'b0, in_mantissa} + (MAN_W+1)'(inc);

    always_comb begin
        inc = 1'b0;
        case (round_mode)
            RND_IEEE_ZERO: inc = 1'b0;
            RND_IEEE_PINF: inc = !in_sign && in_inexact;
            RND_IEEE_NINF: inc = in_sign && in_inexact;
            RND_NEAR_UP:   inc = in_guard;
            RND_AWAY_ZERO: inc = in_inexact;
            RND_IEEE_NEAR: inc = in_guard && (in_sticky || in_mantissa[0]);
            default:       inc = in_guard && (in_sticky || in_mantissa[0]);
        endcase
    end

    // Directed modes that round toward zero saturate to max-finite instead of infinity.
    always_comb begin
        maxfin = 1'b0;
        case (round_mode)
            RND_IEEE_ZERO: maxfin = 1'b1;
            RND_IEEE_PINF: maxfin = in_sign;
            RND_IEEE_NINF: maxfin = !in_sign;
            default:       maxfin = 1'b0;
        endcase
    end

    logic              s1_valid;
    logic              s1_sign;
    logic [XEXP_W-1:0] s1_exp;
    logic [MAN_W:0]    s1_man;
    logic              s1_inexact;
    logic              s1_maxfin;
    logic              s1_uf;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_sign    <= 1'b0;
            s1_exp     <= '0;
            s1_man     <= '0;
            s1_inexact <= 1'b0;
            s1_maxfin  <= 1'b0;
            s1_uf      <= 1'b0;
        end else if (adv) begin
            s1_valid   <= in_valid;
            s1_sign    <= in_sign;
            s1_exp     <= in_exponent;
            s1_man     <= man_rnd;
            s1_inexact <= in_inexact;
            s1_maxfin  <= maxfin;
            s1_uf      <= pre_uf;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: carry into exponent, range checks, packing
    // ------------------------------------------------------------------
    logic signed [XEXP_W:0] post_exp;
    logic [EXP_W+MAN_W:0]   res_z;
    logic                   res_ovf;
    logic                   res_uf;
    logic                   res_ix;

    // A carry leaves the low fraction bits at zero, so only the exponent needs bumping.
    assign post_exp = {s1_exp[XEXP_W-1], s1_exp} + {{XEXP_W{1'b0}}, s1_man[MAN_W]};

    always_comb begin
        res_z   = {s1_sign, post_exp[EXP_W-1:0], s1_man[MAN_W-1:0]};
        res_ovf = 1'b0;
        res_uf  = 1'b0;
        res_ix  = s1_inexact;
        if (s1_uf) begin
            res_z  = {s1_sign, MAG_ZERO[EXP_W+MAN_W-1:0]};
            res_uf = 1'b1;
            res_ix = 1'b1;
        end else if (post_exp >= EXP_LIMIT) begin
            res_ovf = 1'b1;
            res_ix  = 1'b1;
            if (s1_maxfin) begin
                res_z = {s1_sign, EXP_MAXF, MAN_ONES};
            end else begin
                res_z = {s1_sign, EXP_INF, MAN_ZERO};
            end
        end
    end

    logic [EXP_W+MAN_W:0] z_q;
    logic                 ovf_q;
    logic                 uf_q;
    logic                 ix_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            z_q       <= '0;
            ovf_q     <= 1'b0;
            uf_q      <= 1'b0;
            ix_q      <= 1'b0;
        end else if (adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                z_q   <= res_z;
                ovf_q <= res_ovf;
                uf_q  <= res_uf;
                ix_q  <= res_ix;
            end
        end
    end

    assign z         = z_q;
    assign overflow  = out_valid & ovf_q;
    assign underflow = out_valid & uf_q;
    assign inexact   = out_valid & ix_q;

    // ------------------------------------------------------------------
    // Accumulated exception flags
    // ------------------------------------------------------------------
`ifdef ROUND_FLAGS_STICKY_EN
    logic [2:0] acc_q;
    logic       hs;
    assign hs = out_valid & out_ready;

    // Clear wins over the old value, but a beat retired in the same cycle still lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= 3'b000;
        end else begin
            acc_q <= (flags_clr ? 3'b000 : acc_q) |
                     (hs ? {overflow, underflow, inexact} : 3'b000);
        end
    end
    assign flags_acc = acc_q;
`else
    logic unused_flags_clr;
    assign unused_flags_clr = flags_clr;
    assign flags_acc        = 3'b000;
`endif

    a_stall_stable: assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=> (out_valid && $stable(z)));

endmodule

// File: tb/tb_round_pipe.sv
// Bench for round_pipe: directed rounding vectors, randomized streams against an
// arithmetic reference model, backpressure, mid-stream reset and accumulated flags.
module tb_round_pipe;

    localparam int EXP_W  = 8;
    localparam int MAN_W  = 23;
    localparam int XEXP_W = 10;
    localparam int ZW     = 1 + EXP_W + MAN_W;
    localparam int RW     = ZW + 3;

    localparam logic [2:0] M_NEAR = 3'd0;
    localparam logic [2:0] M_ZERO = 3'd1;
    localparam logic [2:0] M_PINF = 3'd2;
    localparam logic [2:0] M_NINF = 3'd3;
    localparam logic [2:0] M_NUP  = 3'd4;
    localparam logic [2:0] M_AWAY = 3'd5;

`ifdef ROUND_FLAGS_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              in_sign = 1'b0;
    logic [XEXP_W-1:0] in_exponent = '0;
    logic [MAN_W-1:0]  in_mantissa = '0;
    logic              in_guard = 1'b0;
    logic              in_sticky = 1'b0;
    logic [2:0]        round_mode = 3'd0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [ZW-1:0]     z;
    logic              inexact;
    logic              overflow;
    logic              underflow;
    logic              flags_clr = 1'b0;
    logic [2:0]        flags_acc;

    always #5 clk = ~clk;

    round_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W), .XEXP_W(XEXP_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_exponent(in_exponent), .in_mantissa(in_mantissa),
        .in_guard(in_guard), .in_sticky(in_sticky), .round_mode(round_mode),
        .out_valid(out_valid), .out_ready(out_ready), .z(z), .inexact(inexact),
        .overflow(overflow), .underflow(underflow), .flags_clr(flags_clr),
        .flags_acc(flags_acc)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [RW-1:0] exp_q[$];
    bit saw_block;
    int last_cycles;

    // Reference: round the full significand as an integer, renormalise, then range-check.
    function automatic logic [RW-1:0] model(input logic sign, input int e, input logic [22:0] man,
                                            input logic g, input logic s, input logic [2:0] mode);
        longint sig;
        int ex;
        logic up, ix, maxfin;
        if (e <= 0) return {sign, 31'b0, 3'b011};
        ix = g | s;
        case (mode)
            M_ZERO:  up = 1'b0;
            M_PINF:  up = !sign && ix;
            M_NINF:  up = sign && ix;
            M_NUP:   up = g;
            M_AWAY:  up = ix;
            default: up = g && (s || man[0]);
        endcase
        sig = (64'd1 << 23) + longint'(man) + longint'(up);
        ex = e;
        if (sig >= (64'd1 << 24)) begin
            sig = sig / 2;
            ex = ex + 1;
        end
        if (ex >= 255) begin
            maxfin = (mode == M_ZERO) || (mode == M_PINF && sign) || (mode == M_NINF && !sign);
            return maxfin ? {sign, 8'hFE, 23'h7FFFFF, 3'b101} : {sign, 8'hFF, 23'h000000, 3'b101};
        end
        return {sign, ex[7:0], sig[22:0], 2'b00, ix};
    endfunction

    task automatic set_beat(input logic sign, input int e, input logic [22:0] man,
                            input logic g, input logic s, input logic [2:0] mode);
        in_sign     = sign;
        in_exponent = 10'(e);
        in_mantissa = man;
        in_guard    = g;
        in_sticky   = s;
        round_mode  = mode;
    endtask

    task automatic rand_inputs();
        int sel, e;
        sel = int'($urandom_range(9));
        case (sel)
            0:       e = -int'($urandom_range(8));
            1:       e = 252 + int'($urandom_range(3));
            2:       e = 256 + int'($urandom_range(255));
            default: e = 1 + int'($urandom_range(253));
        endcase
        set_beat(1'($urandom_range(1)), e,
                 ($urandom_range(3) == 0) ? 23'h7FFFFF : 23'($urandom),
                 1'($urandom_range(1)), 1'($urandom_range(1)), 3'($urandom_range(7)));
    endtask

    // Serial beat with out_ready high: returns after the result has been taken.
    task automatic send_serial(input logic sign, input int e, input logic [22:0] man,
                               input logic g, input logic s, input logic [2:0] mode);
        set_beat(sign, e, man, g, s, mode);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || z !== '0 || {overflow, underflow, inexact} !== 3'b000 ||
            flags_acc !== 3'b000 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_state: out_valid=%b z=%h flags=%b acc=%b in_ready=%b, required 0 0 000 000 1",
                     out_valid, z, {overflow, underflow, inexact}, flags_acc, in_ready);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    typedef struct {
        string      name;
        logic       sign;
        int         e;
        logic [22:0] man;
        logic       g;
        logic       s;
        logic [2:0] mode;
        logic [31:0] z;
        logic [2:0] f;
    } vec_t;

    task automatic test_directed();
        vec_t v[$];
        v.push_back('{"near_tie_odd",  1'b0, 127, 23'h000001, 1'b1, 1'b0, M_NEAR, 32'h3F800002, 3'b001});
        v.push_back('{"near_tie_even", 1'b0, 127, 23'h000000, 1'b1, 1'b0, M_NEAR, 32'h3F800000, 3'b001});
        v.push_back('{"carry",         1'b0, 127, 23'h7FFFFF, 1'b1, 1'b0, M_NEAR, 32'h40000000, 3'b001});
        v.push_back('{"ovf_near",      1'b0, 254, 23'h7FFFFF, 1'b1, 1'b0, M_NEAR, 32'h7F800000, 3'b101});
        v.push_back('{"ovf_zero",      1'b0, 254, 23'h7FFFFF, 1'b1, 1'b0, M_ZERO, 32'h7F7FFFFF, 3'b001});
        v.push_back('{"ninf_neg",      1'b1, 127, 23'h000000, 1'b0, 1'b1, M_NINF, 32'hBF800001, 3'b001});
        v.push_back('{"pinf_neg",      1'b1, 127, 23'h000000, 1'b0, 1'b1, M_PINF, 32'hBF800000, 3'b001});
        v.push_back('{"away_neg",      1'b1, 127, 23'h000000, 1'b0, 1'b1, M_AWAY, 32'hBF800001, 3'b001});
        v.push_back('{"near_up",       1'b0, 127, 23'h000000, 1'b1, 1'b0, M_NUP,  32'h3F800001, 3'b001});
        v.push_back('{"uf_zero_exp",   1'b1, 0,   23'h000123, 1'b1, 1'b0, M_NEAR, 32'h80000000, 3'b011});
        v.push_back('{"uf_neg_exp",    1'b0, -5,  23'h7FFFFF, 1'b0, 1'b0, M_NEAR, 32'h00000000, 3'b011});
        v.push_back('{"maxf_pinf_neg", 1'b1, 255, 23'h000000, 1'b0, 1'b0, M_PINF, 32'hFF7FFFFF, 3'b101});
        v.push_back('{"inf_ninf_neg",  1'b1, 255, 23'h000000, 1'b0, 1'b0, M_NINF, 32'hFF800000, 3'b101});
        v.push_back('{"ovf_pinf_pos",  1'b0, 254, 23'h7FFFFF, 1'b0, 1'b1, M_PINF, 32'h7F800000, 3'b101});
        v.push_back('{"mode7_near",    1'b0, 127, 23'h000001, 1'b1, 1'b0, 3'd7,   32'h3F800002, 3'b001});
        v.push_back('{"exact",         1'b0, 100, 23'h012345, 1'b0, 1'b0, M_NEAR, 32'h32012345, 3'b000});
        out_ready = 1'b1;
        foreach (v[i]) begin
            set_beat(v[i].sign, v[i].e, v[i].man, v[i].g, v[i].s, v[i].mode);
            in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL latency_%s: out_valid=%b after one edge, required 0", v[i].name, out_valid);
            end
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b1 || z !== v[i].z || {overflow, underflow, inexact} !== v[i].f) begin
                n_fail++;
                $display("FAIL directed_%s: out_valid=%b z=%h ovf/uf/ix=%b, required 1 z=%h ovf/uf/ix=%b",
                         v[i].name, out_valid, z, {overflow, underflow, inexact}, v[i].z, v[i].f);
            end
            @(negedge clk);
        end
    endtask

    // ready_mode: 0 random ready, 1 three-cycle stall mid-stream, 2 always ready.
    task automatic test_stream(input int n, input int ready_mode);
        int got, cyc;
        bit hold;
        logic [ZW-1:0] held_z;
        logic [2:0] held_f;
        logic r;
        logic [RW-1:0] want;
        got = 0;
        cyc = 0;
        hold = 1'b0;
        held_z = '0;
        held_f = '0;
        saw_block = 1'b0;
        fork
            begin
                for (int i = 0; i < n; i++) begin
                    int waits;
                    bit acc;
                    waits = 0;
                    acc = 1'b0;
                    rand_inputs();
                    in_valid = 1'b1;
                    while (!acc && waits < 200) begin
                        #1;
                        acc = in_ready;
                        if (!acc) begin
                            saw_block = 1'b1;
                            waits++;
                            @(negedge clk);
                        end
                    end
                    if (acc) exp_q.push_back(model(in_sign, int'($signed(in_exponent)), in_mantissa,
                                                   in_guard, in_sticky, round_mode));
                    @(negedge clk);
                end
                in_valid = 1'b0;
            end
            begin
                while (got < n && cyc < 50 * n + 100) begin
                    @(negedge clk);
                    cyc++;
                    if (hold) begin
                        n_checks++;
                        if (out_valid !== 1'b1 || z !== held_z || {overflow, underflow, inexact} !== held_f) begin
                            n_fail++;
                            $display("FAIL stall_hold: out_valid=%b z=%h flags=%b, required 1 z=%h flags=%b",
                                     out_valid, z, {overflow, underflow, inexact}, held_z, held_f);
                        end
                    end
                    case (ready_mode)
                        0:       r = ($urandom_range(99) < 70);
                        1:       r = !(cyc >= 3 && cyc <= 5);
                        default: r = 1'b1;
                    endcase
                    out_ready = r;
                    hold = (out_valid === 1'b1) && !r;
                    held_z = z;
                    held_f = {overflow, underflow, inexact};
                    if (out_valid === 1'b1 && r) begin
                        got++;
                        n_checks++;
                        if (exp_q.size() == 0) begin
                            n_fail++;
                            $display("FAIL stream_extra: z=%h delivered with no beat outstanding", z);
                        end else begin
                            want = exp_q.pop_front();
                            if ({z, overflow, underflow, inexact} !== want) begin
                                n_fail++;
                                $display("FAIL stream_beat%0d: z=%h ovf/uf/ix=%b, required z=%h ovf/uf/ix=%b",
                                         got, z, {overflow, underflow, inexact}, want[RW-1:3], want[2:0]);
                            end
                        end
                    end
                end
            end
        join
        last_cycles = cyc;
        n_checks++;
        if (got != n) begin
            n_fail++;
            $display("FAIL stream_timeout: received %0d beats, required %0d", got, n);
        end
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL stream_drain: out_valid=%b pending=%0d, required 0 0", out_valid, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_random();
        test_stream(300, 0);
    endtask

    task automatic test_backpressure();
        test_stream(4, 1);
        n_checks++;
        if (saw_block !== 1'b1) begin
            n_fail++;
            $display("FAIL backpressure_in_ready: in_ready never dropped during stall, required a drop");
        end
    endtask

    task automatic test_back_to_back();
        test_stream(20, 2);
        n_checks++;
        if (last_cycles > 22) begin
            n_fail++;
            $display("FAIL back_to_back_rate: 20 beats took %0d cycles, required <= 22", last_cycles);
        end
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b1;
        set_beat(1'b0, 127, 23'h000010, 1'b0, 1'b0, M_NEAR);
        in_valid = 1'b1;
        @(negedge clk);
        set_beat(1'b1, 130, 23'h000020, 1'b0, 1'b0, M_NEAR);
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_inflight: out_valid=%b before reset, required 1", out_valid);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || z !== '0) begin
            n_fail++;
            $display("FAIL midreset_clear: out_valid=%b z=%h, required 0 00000000", out_valid, z);
        end
        repeat (2) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL midreset_dropped: out_valid=%b z=%h after reset, required 0", out_valid, z);
            end
        end
    endtask

    task automatic test_flags();
        logic [2:0] want;
        out_ready = 1'b1;
        flags_clr = 1'b1;
        @(negedge clk);
        flags_clr = 1'b0;
        n_checks++;
        if (flags_acc !== 3'b000) begin
            n_fail++;
            $display("FAIL flags_clear0: flags_acc=%b, required 000", flags_acc);
        end
        send_serial(1'b0, 0, 23'h000055, 1'b1, 1'b0, M_NEAR);
        send_serial(1'b0, 120, 23'h000100, 1'b0, 1'b0, M_NEAR);
        send_serial(1'b1, 140, 23'h3ABCDE, 1'b0, 1'b0, M_ZERO);
        want = STICKY ? 3'b011 : 3'b000;
        n_checks++;
        if (flags_acc !== want) begin
            n_fail++;
            $display("FAIL flags_sticky: flags_acc=%b, required %b", flags_acc, want);
        end
        // Inexact beat retires in the same cycle as a clear.
        set_beat(1'b0, 120, 23'h000100, 1'b1, 1'b1, M_NEAR);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        flags_clr = 1'b1;
        @(negedge clk);
        flags_clr = 1'b0;
        want = STICKY ? 3'b001 : 3'b000;
        n_checks++;
        if (flags_acc !== want) begin
            n_fail++;
            $display("FAIL flags_clear_same_cycle: flags_acc=%b, required %b", flags_acc, want);
        end
        flags_clr = 1'b1;
        @(negedge clk);
        flags_clr = 1'b0;
        n_checks++;
        if (flags_acc !== 3'b000) begin
            n_fail++;
            $display("FAIL flags_clear_final: flags_acc=%b, required 000", flags_acc);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_midstream();
        test_flags();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
